counter32_modes: RTL and testbench

- Behavioural 32-bit multi-mode counter: the DUT that the 32-bit conductual bench and scoreboard drive.
- Receives enable/modo/D from the driver; returns Q and rco.
- Adds a saturating wrap-event counter and a load acknowledge so the checker can cross-check scoreboard wrap counts without recomputing them.
- Instantiated directly under the top-level testbench alongside scoreboard32.

---
 rtl/counter32_modes.sv | 83 ++++++++
 tb/tb_counter32_modes.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/counter32_modes.sv
// Multi-mode counter with four modes: count up by STEP, count down by 1, count up by 1, and load.
// Also provides a saturating wrap-event counter and a load acknowledge.
module counter32_modes #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 3,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load_ack,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             wrap_sat
);

    localparam logic [WIDTH:0]   StepExt = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   OneExt  = (WIDTH+1)'(1);
    localparam logic [WRAPW-1:0] WrapMax = '1;

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic             r_load_ack;
    logic [WRAPW-1:0] r_wrap_cnt;
    logic             r_wrap_sat;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap;
    logic             w_load;
    logic [WRAPW-1:0] w_wrap_cnt_next;

    // Bit WIDTH of the widened sum is the carry (up) or borrow (down) of the step.
    always_comb begin
        w_sum    = {1'b0, r_q};
        w_load   = 1'b0;
        w_wrap   = 1'b0;
        w_q_next = r_q;
        if (enable) begin
            unique case (modo)
                2'b00: w_sum = {1'b0, r_q} + StepExt;
                2'b01: w_sum = {1'b0, r_q} - OneExt;
                2'b10: w_sum = {1'b0, r_q} + OneExt;
                2'b11: w_load = 1'b1;
            endcase
            w_q_next = w_load ? D : w_sum[WIDTH-1:0];
            w_wrap   = ~w_load & w_sum[WIDTH];
        end
    end

    always_comb begin
        w_wrap_cnt_next = r_wrap_cnt;
        if (w_wrap && (r_wrap_cnt != WrapMax)) begin
            w_wrap_cnt_next = r_wrap_cnt + WRAPW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q        <= '0;
            r_rco      <= 1'b0;
            r_load_ack <= 1'b0;
            r_wrap_cnt <= '0;
            r_wrap_sat <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_rco      <= w_wrap;
            r_load_ack <= w_load;
            r_wrap_cnt <= w_wrap_cnt_next;
            r_wrap_sat <= r_wrap_sat | (w_wrap_cnt_next == WrapMax);
        end
    end

    assign Q        = r_q;
    assign rco      = r_rco;
    assign load_ack = r_load_ack;
    assign wrap_cnt = r_wrap_cnt;
    assign wrap_sat = r_wrap_sat;

endmodule

// File: tb/tb_counter32_modes.sv
// Randomized and directed bench for counter32_modes against a modular-arithmetic reference model.
// A 4-bit instance is used to reach wrap-counter saturation in reasonable time.
module tb_counter32_modes;

    typedef struct {
        longint unsigned q;
        bit              rco;
        bit              ack;
        int unsigned     wc;
        bit              sat;
    } mstate_t;

    localparam longint unsigned Mod32 = 64'h1_0000_0000;
    localparam longint unsigned Mod4  = 64'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en32 = 1'b0;
    logic [1:0]  modo32 = 2'b00;
    logic [31:0] d32 = '0;
    logic [31:0] q32;
    logic        rco32, ack32, sat32;
    logic [7:0]  wc32;
    logic        en4 = 1'b0;
    logic [1:0]  modo4 = 2'b00;
    logic [3:0]  d4 = '0;
    logic [3:0]  q4;
    logic        rco4, ack4, sat4;
    logic [7:0]  wc4;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned rco4_after_sat = 0;
    mstate_t     m32, m4;

    counter32_modes #(.WIDTH(32), .STEP(3), .WRAPW(8)) u_dut32 (
        .clk(clk), .reset(reset), .enable(en32), .modo(modo32), .D(d32),
        .Q(q32), .rco(rco32), .load_ack(ack32), .wrap_cnt(wc32), .wrap_sat(sat32)
    );

    counter32_modes #(.WIDTH(4), .STEP(3), .WRAPW(8)) u_dut4 (
        .clk(clk), .reset(reset), .enable(en4), .modo(modo4), .D(d4),
        .Q(q4), .rco(rco4), .load_ack(ack4), .wrap_cnt(wc4), .wrap_sat(sat4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned obs,
                            input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mstate_t zero_state();
        mstate_t s;
        s.q = 0; s.rco = 0; s.ack = 0; s.wc = 0; s.sat = 0;
        return s;
    endfunction

    // Reference next state from modular arithmetic: wrap means the true result left [0, modn).
    function automatic mstate_t mstep(mstate_t s, longint unsigned modn, bit en,
                                      bit [1:0] m, longint unsigned d);
        mstate_t n = s;
        longint unsigned t;
        n.rco = 0;
        n.ack = 0;
        if (en) begin
            case (m)
                2'b00: begin t = s.q + 3;  n.rco = (t >= modn); n.q = t % modn; end
                2'b01: begin n.rco = (s.q == 0); n.q = (s.q + modn - 1) % modn; end
                2'b10: begin t = s.q + 1;  n.rco = (t >= modn); n.q = t % modn; end
                default: begin n.q = d % modn; n.ack = 1; end
            endcase
        end
        if (n.rco && n.wc < 255) n.wc = n.wc + 1;
        if (n.wc == 255) n.sat = 1;
        return n;
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".q32"},   q32,   m32.q);
        check_eq({tag, ".rco32"}, rco32, m32.rco);
        check_eq({tag, ".ack32"}, ack32, m32.ack);
        check_eq({tag, ".wc32"},  wc32,  m32.wc);
        check_eq({tag, ".sat32"}, sat32, m32.sat);
        check_eq({tag, ".q4"},    q4,    m4.q);
        check_eq({tag, ".rco4"},  rco4,  m4.rco);
        check_eq({tag, ".ack4"},  ack4,  m4.ack);
        check_eq({tag, ".wc4"},   wc4,   m4.wc);
        check_eq({tag, ".sat4"},  sat4,  m4.sat);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        m32 = mstep(m32, Mod32, en32, modo32, d32);
        m4  = mstep(m4, Mod4, en4, modo4, d4);
        #1;
        compare_all(tag);
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        m32 = zero_state();
        m4  = zero_state();
        #1;
        compare_all({tag, ".async"});
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic drive32(input bit en, input bit [1:0] m, input logic [31:0] d);
        en32 = en; modo32 = m; d32 = d;
    endtask

    initial begin
        m32 = zero_state();
        m4  = zero_state();
        async_reset("init");

        drive32(1, 2'b10, '0);
        for (int i = 1; i <= 5; i++) begin
            tick("tp1");
            check_eq("tp1.q_const", q32, i);
        end

        drive32(1, 2'b11, 32'hFFFF_FFFE);
        tick("tp2.load");
        check_eq("tp2.ack_const", ack32, 1);
        drive32(1, 2'b10, '0);
        tick("tp2.up1");
        tick("tp2.up2");
        check_eq("tp2.wrap_q", q32, 0);
        check_eq("tp2.wrap_rco", rco32, 1);
        tick("tp2.up3");
        check_eq("tp2.after_rco", rco32, 0);

        drive32(1, 2'b11, 32'hFFFF_FFFD);
        tick("tp3.load");
        drive32(1, 2'b00, '0);
        tick("tp3.s1");
        check_eq("tp3.rco", rco32, 1);
        tick("tp3.s2");
        check_eq("tp3.q3", q32, 3);

        drive32(1, 2'b11, 32'h0000_0001);
        tick("tp4.load");
        drive32(1, 2'b01, '0);
        for (int i = 0; i < 3; i++) tick("tp4.down");
        check_eq("tp4.q", q32, 32'hFFFF_FFFE);

        drive32(1, 2'b11, 32'h0000_000E);
        tick("tp5.load");
        drive32(1, 2'b11, 32'h0000_000E);
        tick("tp5.load_same");
        drive32(1, 2'b10, '0);
        tick("tp5.c1");
        tick("tp5.c2");
        drive32(0, 2'b10, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            tick("tp5.hold");
            check_eq("tp5.hold_q", q32, 32'h10);
        end
        async_reset("tp5");
        check_eq("tp5.q_after_rst", q32, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] dv;
            case ($urandom_range(0, 2))
                0: dv = $urandom;
                1: dv = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
                default: dv = 32'($urandom_range(0, 4));
            endcase
            drive32($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), dv);
            tick("rand");
        end
        drive32(0, 2'b00, '0);

        en4 = 1'b1; modo4 = 2'b11; d4 = 4'hF;
        tick("tp6.load");
        modo4 = 2'b10;
        for (int i = 0; i < 260 * 16; i++) begin
            tick("tp6.up");
            if (m4.sat && rco4) rco4_after_sat++;
        end
        check_eq("tp6.wc_sat", wc4, 255);
        check_eq("tp6.sat", sat4, 1);
        check_eq("tp6.late_rco", rco4_after_sat, 6);
        en4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
